// File: rtl/pe_window_buffer.sv
// rtl/pe_window_buffer.sv - circular row line buffer presenting a registered ROWS-row window
module pe_window_buffer #(
    parameter int ROW_BYTES = 26,
    parameter int DATA_W    = 8,
    parameter int ROWS      = 3
) (
    input  logic                                 PEclk,
    input  logic                                 rst_n,
    input  logic                                 en,
    input  logic                                 frame_start,
    input  logic                                 din_vld,
    input  logic [ROW_BYTES*DATA_W-1:0]          din,
    input  logic                                 win_rdy,
    output logic                                 win_vld,
    output logic [ROWS*ROW_BYTES*DATA_W-1:0]     win_data,
    output logic [$clog2(ROWS+1)-1:0]            fill_cnt,
    output logic                                 overflow
);

    localparam int ROW_W = ROW_BYTES * DATA_W;
    localparam int WIN_W = ROWS * ROW_W;
    localparam int PW    = $clog2(ROWS);
    localparam int CW    = $clog2(ROWS + 1);

    typedef enum logic {
        FILLING   = 1'b0,
        STREAMING = 1'b1
    } state_t;

    state_t            state_q;
    state_t            state_eff;
    state_t            state_nxt;
    logic [ROW_W-1:0]  rows [ROWS];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     ptr_eff;
    logic [PW-1:0]     ptr_nxt;
    logic [CW-1:0]     fill_eff;
    logic [CW-1:0]     fill_nxt;
    logic              wr;
    logic              produce;
    logic              load;
    logic              drop;
    logic [WIN_W-1:0]  win_nxt;
    int                idx;

    // Next-state, pointer/fill update and window assembly; frame_start rebases the frame
    // before the same-cycle row is considered so that row becomes row 0 of the new frame.
    always_comb begin
        ptr_eff   = frame_start ? '0 : wr_ptr;
        fill_eff  = frame_start ? '0 : fill_cnt;
        state_eff = frame_start ? FILLING : state_q;
        wr        = en & din_vld;
        produce   = wr && ((state_eff == STREAMING) || (fill_eff == CW'(ROWS - 1)));
        load      = produce && (!win_vld || win_rdy);
        drop      = produce && win_vld && !win_rdy;
        ptr_nxt   = ptr_eff;
        fill_nxt  = fill_eff;
        if (wr) begin
            ptr_nxt  = (ptr_eff == PW'(ROWS - 1)) ? '0 : ptr_eff + 1'b1;
            fill_nxt = (fill_eff == CW'(ROWS)) ? fill_eff : fill_eff + 1'b1;
        end
        state_nxt = (fill_nxt == CW'(ROWS)) ? STREAMING : FILLING;
        win_nxt   = '0;
        idx       = 0;
        for (int i = 0; i < ROWS; i++) begin
            // Oldest row sits just after the slot being written; that slot takes din.
            idx = int'(ptr_eff) + 1 + i;
            if (idx >= ROWS) begin
                idx = idx - ROWS;
            end
            if (idx == int'(ptr_eff)) begin
                win_nxt[i*ROW_W +: ROW_W] = din;
            end else begin
                win_nxt[i*ROW_W +: ROW_W] = rows[PW'(idx)];
            end
        end
    end

    // State, line buffer and output window registers with asynchronous reset.
    always_ff @(posedge PEclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FILLING;
            wr_ptr   <= '0;
            fill_cnt <= '0;
            overflow <= 1'b0;
            win_vld  <= 1'b0;
            win_data <= '0;
            for (int i = 0; i < ROWS; i++) begin
                rows[i] <= '0;
            end
        end else begin
            state_q  <= state_nxt;
            wr_ptr   <= ptr_nxt;
            fill_cnt <= fill_nxt;
            overflow <= (overflow & ~frame_start) | drop;
            if (wr) begin
                rows[ptr_eff] <= din;
            end
            if (load) begin
                win_data <= win_nxt;
                win_vld  <= 1'b1;
            end else if (win_vld && win_rdy) begin
                win_vld  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pe_window_buffer.sv
// tb/tb_pe_window_buffer.sv - table-driven bench with window scoreboard for pe_window_buffer
module tb_pe_window_buffer;

    localparam int ROW_BYTES = 26;
    localparam int DATA_W    = 8;
    localparam int ROWS      = 3;
    localparam int ROW_W     = ROW_BYTES * DATA_W;
    localparam int WIN_W     = ROWS * ROW_W;

    logic                   PEclk;
    logic                   rst_n;
    logic                   en;
    logic                   frame_start;
    logic                   din_vld;
    logic [ROW_W-1:0]       din;
    logic                   win_rdy;
    logic                   win_vld;
    logic [WIN_W-1:0]       win_data;
    logic [$clog2(ROWS+1)-1:0] fill_cnt;
    logic                   overflow;

    pe_window_buffer #(.ROW_BYTES(ROW_BYTES), .DATA_W(DATA_W), .ROWS(ROWS)) dut (
        .PEclk       (PEclk),
        .rst_n       (rst_n),
        .en          (en),
        .frame_start (frame_start),
        .din_vld     (din_vld),
        .din         (din),
        .win_rdy     (win_rdy),
        .win_vld     (win_vld),
        .win_data    (win_data),
        .fill_cnt    (fill_cnt),
        .overflow    (overflow)
    );

    initial PEclk = 1'b0;
    always #5 PEclk = ~PEclk;

    typedef struct {
        bit             fs;
        bit             e;
        bit             v;
        logic [7:0]     b;
        bit             r;
        int             ev;
        int             ef;
        int             eo;
        bit             cw;
        logic [WIN_W-1:0] ew;
    } vec_t;

    vec_t             tbl[$];
    logic [WIN_W-1:0] sb[$];
    logic [7:0]       hist[$];
    int               mfill;
    bit               mvld;
    int               n_tests;
    int               n_fail;

    function automatic logic [WIN_W-1:0] mk3(input logic [7:0] b2, input logic [7:0] b1, input logic [7:0] b0);
        logic [WIN_W-1:0] w;
        w = '0;
        w[0*ROW_W +: ROW_W] = {ROW_BYTES{b0}};
        w[1*ROW_W +: ROW_W] = {ROW_BYTES{b1}};
        w[2*ROW_W +: ROW_W] = {ROW_BYTES{b2}};
        return w;
    endfunction

    task automatic chk_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_win(input string name, input logic [WIN_W-1:0] act, input logic [WIN_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input bit fs, input bit e, input bit v, input logic [7:0] b, input bit r,
                       input int ev, input int ef, input int eo, input bit cw, input logic [WIN_W-1:0] ew);
        vec_t t;
        t.fs = fs; t.e = e; t.v = v; t.b = b; t.r = r;
        t.ev = ev; t.ef = ef; t.eo = eo; t.cw = cw; t.ew = ew;
        tbl.push_back(t);
    endtask

    // Scoreboard: every accepted transfer must match the oldest expected window.
    always @(negedge PEclk) begin
        if (rst_n && win_vld && win_rdy) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected: got window %h expected none", win_data);
            end else begin
                chk_win("sb_window", win_data, sb.pop_front());
            end
        end
    end

    // One cycle: drive inputs, advance the reference model, clock, then check outputs.
    task automatic step(input vec_t t, input string tag);
        logic [WIN_W-1:0] w;
        bit xfer;
        bit prod;
        frame_start = t.fs;
        en          = t.e;
        din_vld     = t.v;
        din         = {ROW_BYTES{t.b}};
        win_rdy     = t.r;
        xfer = mvld && t.r;
        prod = 1'b0;
        if (t.fs) begin
            mfill = 0;
            hist.delete();
        end
        if (t.e && t.v) begin
            hist.push_back(t.b);
            if (hist.size() > ROWS) void'(hist.pop_front());
            if (mfill < ROWS) mfill++;
            if (mfill == ROWS) prod = 1'b1;
        end
        if (prod && (!mvld || t.r)) begin
            w = '0;
            for (int i = 0; i < ROWS; i++) w[i*ROW_W +: ROW_W] = {ROW_BYTES{hist[i]}};
            sb.push_back(w);
            mvld = 1'b1;
        end else if (xfer && !prod) begin
            mvld = 1'b0;
        end
        @(posedge PEclk);
        #1;
        chk_int({tag, "_win_vld"}, int'(win_vld), t.ev);
        chk_int({tag, "_fill_cnt"}, int'(fill_cnt), t.ef);
        chk_int({tag, "_overflow"}, int'(overflow), t.eo);
        if (t.cw) chk_win({tag, "_win_data"}, win_data, t.ew);
    endtask

    initial begin
        vec_t t;
        n_tests = 0;
        n_fail  = 0;
        mfill   = 0;
        mvld    = 1'b0;
        rst_n = 1'b0; en = 1'b0; frame_start = 1'b0; din_vld = 1'b0; din = '0; win_rdy = 1'b0;
        repeat (2) @(posedge PEclk);
        #1;
        chk_int("reset_win_vld", int'(win_vld), 0);
        chk_int("reset_fill_cnt", int'(fill_cnt), 0);
        chk_int("reset_overflow", int'(overflow), 0);
        chk_win("reset_win_data", win_data, '0);
        rst_n = 1'b1;

        //   fs e  v  byte   r  vld fill ovf chk data
        add(0, 1, 1, 8'h00, 1, 0, 1, 0, 0, '0);
        add(0, 1, 1, 8'h01, 1, 0, 2, 0, 0, '0);
        add(0, 1, 1, 8'h02, 1, 1, 3, 0, 1, mk3(8'h02, 8'h01, 8'h00));
        add(0, 1, 1, 8'h03, 1, 1, 3, 0, 1, mk3(8'h03, 8'h02, 8'h01));
        add(0, 1, 1, 8'h04, 1, 1, 3, 0, 1, mk3(8'h04, 8'h03, 8'h02));
        add(0, 1, 1, 8'h05, 1, 1, 3, 0, 0, '0);
        add(0, 1, 1, 8'h06, 1, 1, 3, 0, 0, '0);
        add(0, 1, 1, 8'h07, 1, 1, 3, 0, 1, mk3(8'h07, 8'h06, 8'h05));
        add(0, 0, 0, 8'h00, 1, 0, 3, 0, 0, '0);
        add(1, 1, 1, 8'h00, 1, 0, 1, 0, 0, '0);
        add(0, 1, 1, 8'h01, 1, 0, 2, 0, 0, '0);
        add(0, 1, 1, 8'h02, 0, 1, 3, 0, 1, mk3(8'h02, 8'h01, 8'h00));
        add(0, 1, 1, 8'h03, 0, 1, 3, 1, 1, mk3(8'h02, 8'h01, 8'h00));
        add(0, 0, 0, 8'h00, 1, 0, 3, 1, 0, '0);
        add(1, 1, 1, 8'hAA, 1, 0, 1, 0, 0, '0);
        add(0, 1, 1, 8'hBB, 1, 0, 2, 0, 0, '0);
        add(0, 1, 1, 8'hCC, 1, 1, 3, 0, 1, mk3(8'hCC, 8'hBB, 8'hAA));
        add(0, 0, 1, 8'hDD, 1, 0, 3, 0, 0, '0);
        add(0, 0, 1, 8'hDD, 1, 0, 3, 0, 0, '0);
        add(0, 0, 1, 8'hDD, 1, 0, 3, 0, 0, '0);
        add(0, 1, 1, 8'hEE, 0, 1, 3, 0, 1, mk3(8'hEE, 8'hCC, 8'hBB));

        foreach (tbl[i]) begin
            step(tbl[i], $sformatf("vec%0d", i));
        end

        // Asynchronous reset while a window is pending.
        #2;
        rst_n = 1'b0;
        #1;
        chk_int("async_rst_win_vld", int'(win_vld), 0);
        chk_int("async_rst_fill_cnt", int'(fill_cnt), 0);
        chk_int("async_rst_overflow", int'(overflow), 0);
        chk_win("async_rst_win_data", win_data, '0);
        sb.delete();
        hist.delete();
        mfill = 0;
        mvld  = 1'b0;
        @(posedge PEclk);
        #1;
        rst_n = 1'b1;

        // After release a window needs ROWS fresh rows.
        t = '{fs:0, e:1, v:1, b:8'h11, r:1, ev:0, ef:1, eo:0, cw:0, ew:'0};
        step(t, "post_rst0");
        t.b = 8'h22; t.ef = 2;
        step(t, "post_rst1");
        t.b = 8'h33; t.ef = 3; t.ev = 1; t.cw = 1; t.ew = mk3(8'h33, 8'h22, 8'h11);
        step(t, "post_rst2");
        t = '{fs:0, e:0, v:0, b:8'h00, r:1, ev:0, ef:3, eo:0, cw:0, ew:'0};
        step(t, "drain");
        step(t, "drain2");

        chk_int("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
